luces_ctrl: RTL
===============

Name: luces_ctrl

Overview:
- Sequencing controller for the 8-LED light chaser.
- Drives the chaser's ENABLE input with single-cycle step strobes derived from CLK through a programmable prescaler.
- Provides start/pause/single-step control and a selectable speed level from pre-synchronised push-button inputs.
- Sits between the board buttons (after synchronisers) and the chaser FSM.

Parameters:
- BASE_DIV, 3125000, step period in CLK cycles at the fastest level (16 Hz at 50 MHz).
- N_LEVELS, 8, number of speed levels, 2..8.
- INIT_LEVEL, 0, speed level loaded at reset, 0..N_LEVELS-1.
- CNT_W, 32, prescaler counter width. Must satisfy BASE_DIV<<(N_LEVELS-1) <= 2^CNT_W.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  synchronous reset, active-high
- BTN_RUN  input  1  run/pause toggle button, level, already synchronised
- BTN_STEP  input  1  single-step button, level, already synchronised
- BTN_UP  input  1  speed-up button, level, already synchronised
- BTN_DOWN  input  1  speed-down button, level, already synchronised
- ENABLE  output  1  one-cycle step strobe to chaser
- LEVEL  output  3  current speed level, 0 = slowest
- RUNNING  output  1  high in state RUN
- PAUSED  output  1  high in state PAUSE

Behaviour:
- Reset (RST high at a CLK edge):
  - state=IDLE, LEVEL=INIT_LEVEL, counter=0, ENABLE=0.
  - All button edge-detect registers load 0, so a button held through reset registers as an edge on the first post-reset cycle.
  - RST overrides every other input. Reset mid-period discards the count.
- Edge detect: each BTN_x has a registered copy x_q. Event = BTN_x & ~x_q, evaluated in the same cycle. Only rising edges act; holding a button produces one event.
- Period: PERIOD = BASE_DIV << (N_LEVELS-1-LEVEL). Level N_LEVELS-1 gives BASE_DIV; each lower level doubles it.
- States:
  - IDLE: no stepping. RUN event -> RUN, counter cleared. STEP event -> one ENABLE pulse, stay IDLE.
  - RUN:
    - Counter increments every cycle.
    - When counter == PERIOD-1: counter<=0, ENABLE<=1 for exactly one cycle.
    - First strobe occurs PERIOD cycles after the RUN event edge.
    - RUN event -> PAUSE. STEP events are ignored in RUN.
  - PAUSE:
    - Counter holds its value.
    - RUN event -> RUN, and counting resumes from the held value.
    - STEP event -> one ENABLE pulse, stay PAUSE.
- ENABLE is registered. A step-button event sampled at edge k gives ENABLE=1 during cycle k+1 only.
- ENABLE is never high for two consecutive cycles. A STEP event coinciding with a pending period strobe cannot occur, because STEP is ignored in RUN.
- Speed (in every state):
  - UP event: LEVEL+1, saturating at N_LEVELS-1.
  - DOWN event: LEVEL-1, saturating at 0.
  - UP and DOWN events in the same cycle: both ignored, LEVEL unchanged.
  - Any accepted LEVEL change clears the counter, so the new period starts cleanly with no strobe burst.
  - A saturated, ignored press does not clear the counter.
- Simultaneous events in one cycle are all processed: a RUN event and a speed event apply the state change and the LEVEL change together, and the counter clears.
- RUNNING = (state==RUN). PAUSED = (state==PAUSE). Both are registered state decodes.
- LEVEL width is fixed at 3 bits regardless of N_LEVELS. Unused codes are unreachable.

Test Plan (bench parameters: BASE_DIV=4, N_LEVELS=4, INIT_LEVEL=0):
- Reset then idle 100 cycles -> ENABLE never high, LEVEL=0, RUNNING=0, PAUSED=0. Hold BTN_RUN high through reset -> RUN entered on first cycle after RST falls.
- RUN pulse at LEVEL 0 (PERIOD 32) -> RUNNING=1, ENABLE strobes every 32 cycles, first strobe 32 cycles after the event edge, each strobe exactly one cycle wide.
- Four UP pulses -> LEVEL 1,2,3,3 (saturated). In RUN, strobes every 4 cycles after the last accepted change. DOWN and UP asserted on the same cycle -> LEVEL unchanged.
- RUN, wait 10 cycles at PERIOD 32, RUN pulse -> PAUSED=1, no strobes. STEP pulse -> exactly one ENABLE one cycle later. RUN pulse -> next strobe 22 cycles after resume.
- STEP pressed in RUN -> no extra ENABLE. STEP held high for 50 cycles in IDLE -> exactly one ENABLE.
- RST asserted mid-period in RUN at LEVEL 2 -> next cycle IDLE, LEVEL=0, counter 0, no further strobes.

Source files
------------

// File: rtl/luces_if.sv
// Button and chaser-control bundle for the light-chaser sequencer.
interface luces_if;
    logic       BTN_RUN;
    logic       BTN_STEP;
    logic       BTN_UP;
    logic       BTN_DOWN;
    logic       ENABLE;
    logic [2:0] LEVEL;
    logic       RUNNING;
    logic       PAUSED;

    modport master (
        output BTN_RUN, BTN_STEP, BTN_UP, BTN_DOWN,
        input  ENABLE, LEVEL, RUNNING, PAUSED
    );

    modport slave (
        input  BTN_RUN, BTN_STEP, BTN_UP, BTN_DOWN,
        output ENABLE, LEVEL, RUNNING, PAUSED
    );
endinterface

// File: rtl/luces_ctrl.sv
// Step-strobe sequencer for the 8-LED chaser: run/pause/single-step control
// with a programmable prescaler selecting one of N_LEVELS speeds.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no stepping; STEP gives one strobe, RUN starts from count 0
// S_RUN   | prescaler counts, strobe every PERIOD cycles
// S_PAUSE | count frozen; STEP gives one strobe, RUN resumes from the held count
module luces_ctrl #(
    parameter int BASE_DIV   = 3125000,
    parameter int N_LEVELS   = 8,
    parameter int INIT_LEVEL = 0,
    parameter int CNT_W      = 32
) (
    input  logic    CLK,
    input  logic    RST,
    luces_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    localparam logic [2:0]     MAX_LVL  = 3'(N_LEVELS - 1);
    localparam logic [2:0]     INIT_LVL = 3'(INIT_LEVEL);
    localparam logic [CNT_W:0] BASE_EXT = (CNT_W + 1)'(BASE_DIV);
    localparam logic [CNT_W:0] ONE_EXT  = (CNT_W + 1)'(1);

    logic [1:0]       state, state_nx;
    logic [2:0]       level, level_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             enable_q, enable_nx;
    logic             running_q, paused_q;
    logic             run_q, step_q, up_q, dn_q;

    logic             run_ev, step_ev, up_ev, dn_ev;
    logic             up_ok, dn_ok, lvl_chg, tc;
    logic [2:0]       shamt;
    logic [CNT_W:0]   period, period_m1_ext;
    logic [CNT_W-1:0] period_m1;

    assign run_ev  = bus.BTN_RUN  & ~run_q;
    assign step_ev = bus.BTN_STEP & ~step_q;
    assign up_ev   = bus.BTN_UP   & ~up_q;
    assign dn_ev   = bus.BTN_DOWN & ~dn_q;

    // Opposing speed presses cancel; presses at a limit are dropped entirely.
    assign up_ok   = up_ev & ~dn_ev & (level != MAX_LVL);
    assign dn_ok   = dn_ev & ~up_ev & (level != 3'd0);
    assign lvl_chg = up_ok | dn_ok;

    // Period for the current level; the extra MSB keeps the top-level shift
    // exact when PERIOD equals 2^CNT_W.
    assign shamt         = MAX_LVL - level;
    assign period        = BASE_EXT << shamt;
    assign period_m1_ext = period - ONE_EXT;
    assign period_m1     = period_m1_ext[CNT_W-1:0];

    // Terminal count; a speed change in the same cycle restarts the period
    // instead of emitting the old one's strobe.
    assign tc = (state == S_RUN) && (cnt == period_m1) && !lvl_chg;

    // Next-state, counter, level and strobe decision.
    always_comb begin
        state_nx  = state;
        level_nx  = level;
        cnt_nx    = cnt;
        enable_nx = 1'b0;

        case (state)
            S_IDLE: begin
                if (run_ev) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                end else if (step_ev && !enable_q) begin
                    enable_nx = 1'b1;
                end
            end
            S_RUN: begin
                if (tc) begin
                    cnt_nx    = '0;
                    enable_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
                if (run_ev) state_nx = S_PAUSE;
            end
            S_PAUSE: begin
                if (run_ev) begin
                    state_nx = S_RUN;
                end else if (step_ev && !enable_q) begin
                    // A strobe issued on the pausing edge blocks a step on the
                    // very next edge so ENABLE never stays high two cycles.
                    enable_nx = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase

        if (up_ok) level_nx = level + 3'd1;
        if (dn_ok) level_nx = level - 3'd1;
        if (lvl_chg) cnt_nx = '0;
    end

    // State, counter, strobe and button history registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            level     <= INIT_LVL;
            cnt       <= '0;
            enable_q  <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            run_q     <= 1'b0;
            step_q    <= 1'b0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
        end else begin
            state     <= state_nx;
            level     <= level_nx;
            cnt       <= cnt_nx;
            enable_q  <= enable_nx;
            running_q <= (state_nx == S_RUN);
            paused_q  <= (state_nx == S_PAUSE);
            run_q     <= bus.BTN_RUN;
            step_q    <= bus.BTN_STEP;
            up_q      <= bus.BTN_UP;
            dn_q      <= bus.BTN_DOWN;
        end
    end

    assign bus.ENABLE  = enable_q;
    assign bus.LEVEL   = level;
    assign bus.RUNNING = running_q;
    assign bus.PAUSED  = paused_q;

endmodule
